// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

    localparam int unsigned INSN_BYTES       = 4;
    localparam logic [31:0] DEFAULT_BASEADDR = 32'h0100_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; pointers wrap at DEPTH-1 so any DEPTH works.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= wrap_inc(tail_q);
            if (pop)  head_q <= wrap_inc(head_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[tail_q] <= push_data;
    end

    assign pop_data = mem[head_q];
    assign count    = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Decoupled fetch stage: PC generation, one-cycle imem read tracking, and a
// {pc, insn} queue presented to decode over valid/ready.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned       AWIDTH   = 32,
    parameter int unsigned       DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(DEFAULT_BASEADDR),
    parameter int unsigned       DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req_o,
    output logic [AWIDTH-1:0]            imem_addr_o,
    input  logic [DWIDTH-1:0]            imem_data_i,
    input  logic                         redirect_i,
    input  logic [AWIDTH-1:0]            redirect_pc_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [AWIDTH-1:0]            pc_o,
    output logic [DWIDTH-1:0]            insn_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [15:0]                  redirect_cnt_o
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] insn;
    } entry_t;

    logic [AWIDTH-1:0] pc_q;
    logic [AWIDTH-1:0] req_pc_q;
    logic              inflight_q;
    logic [15:0]       redirect_cnt_q;
    logic [CW-1:0]     count;
    logic [CW:0]       occupancy;
    logic              issue;
    logic              push;
    logic              pop;
    logic              valid;
    entry_t            push_entry;
    entry_t            head;

    // An issued read reserves its FIFO slot, so the queue can never overflow.
    always_comb begin
        occupancy  = {1'b0, count} + (CW+1)'(inflight_q);
        issue      = !rst && !redirect_i && (occupancy < (CW+1)'(DEPTH));
        valid      = !rst && !redirect_i && (count != '0);
        push       = inflight_q && !redirect_i;
        pop        = valid && ready_i;
        push_entry = '{pc: req_pc_q, insn: imem_data_i};
    end

    fetch_fifo #(
        .WIDTH (AWIDTH + DWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_i),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= BASEADDR;
            req_pc_q       <= '0;
            inflight_q     <= 1'b0;
            redirect_cnt_q <= '0;
        end else if (redirect_i) begin
            pc_q       <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
            inflight_q <= 1'b0;
            if (redirect_cnt_q != '1) redirect_cnt_q <= redirect_cnt_q + 16'd1;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                req_pc_q <= pc_q;
                pc_q     <= pc_q + AWIDTH'(INSN_BYTES);
            end
        end
    end

    assign imem_req_o     = issue;
    assign imem_addr_o    = pc_q;
    assign valid_o        = valid;
    assign pc_o           = valid ? head.pc   : '0;
    assign insn_o         = valid ? head.insn : '0;
    assign count_o        = count;
    assign redirect_cnt_o = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomised scoreboard bench for fetch_buffer at DEPTH=4 and DEPTH=3.
module tb_fetch_buffer;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        ready_i;
    logic [31:0] imem_data [2];

    logic        req_w   [2];
    logic [31:0] addr_w  [2];
    logic        valid_w [2];
    logic [31:0] pc_w    [2];
    logic [31:0] insn_w  [2];
    logic [15:0] rcnt_w  [2];
    logic [2:0]  cnt4;
    logic [1:0]  cnt3;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    fetch_buffer #(.AWIDTH(32), .DWIDTH(32), .BASEADDR(32'h0100_0000), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .imem_req_o(req_w[0]), .imem_addr_o(addr_w[0]),
        .imem_data_i(imem_data[0]), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .valid_o(valid_w[0]), .ready_i(ready_i), .pc_o(pc_w[0]), .insn_o(insn_w[0]),
        .count_o(cnt4), .redirect_cnt_o(rcnt_w[0]));

    fetch_buffer #(.AWIDTH(32), .DWIDTH(32), .BASEADDR(32'h0100_0000), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .imem_req_o(req_w[1]), .imem_addr_o(addr_w[1]),
        .imem_data_i(imem_data[1]), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .valid_o(valid_w[1]), .ready_i(ready_i), .pc_o(pc_w[1]), .insn_o(insn_w[1]),
        .count_o(cnt3), .redirect_cnt_o(rcnt_w[1]));

    // Reference model: the queue holds exactly what decode should still see.
    int          depth [2] = '{4, 3};
    logic [31:0] m_pc  [2];
    ent_t        m_q   [2][$];
    bit          m_inf [2];
    ent_t        m_infe[2];
    int unsigned m_rc  [2];
    bit          e_req [2];
    bit          e_val [2];
    ent_t        e_head[2];
    ent_t        sb    [2][$];
    logic [31:0] key;
    bit          mem_v [2];
    logic [31:0] mem_d [2];

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] actual=%h required=%h at %0t", name, depth[inst], act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_pc[i]  = 32'h0100_0000;
        m_q[i].delete();
        m_inf[i] = 1'b0;
        m_rc[i]  = 0;
    endtask

    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
        rst = r; redirect_i = rd; redirect_pc_i = rpc; ready_i = rdy;
        for (int i = 0; i < 2; i++) begin
            imem_data[i] = mem_v[i] ? mem_d[i] : $urandom();
            e_req[i]  = !r && !rd && (m_q[i].size() + int'(m_inf[i]) < depth[i]);
            e_val[i]  = !r && !rd && (m_q[i].size() != 0);
            e_head[i] = e_val[i] ? m_q[i][0] : '0;
            if (e_val[i] && rdy) sb[i].push_back(m_q[i][0]);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("imem_req", i, 32'(req_w[i]), 32'(e_req[i]));
            chk("imem_addr", i, addr_w[i], m_pc[i]);
            chk("valid", i, 32'(valid_w[i]), 32'(e_val[i]));
            chk("pc_o", i, pc_w[i], e_head[i].pc);
            chk("insn_o", i, insn_w[i], e_head[i].insn);
            chk("count", i, (i == 0) ? 32'(cnt4) : 32'(cnt3), 32'(m_q[i].size()));
            chk("redirect_cnt", i, 32'(rcnt_w[i]), m_rc[i]);
            mem_v[i] = (req_w[i] === 1'b1);
            mem_d[i] = addr_w[i] ^ key;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                model_reset(i);
            end else if (rd) begin
                m_q[i].delete();
                m_inf[i] = 1'b0;
                m_pc[i]  = rpc & 32'hFFFF_FFFC;
                if (m_rc[i] < 65535) m_rc[i]++;
            end else begin
                if (m_q[i].size() != 0 && rdy) void'(m_q[i].pop_front());
                if (m_inf[i]) m_q[i].push_back(m_infe[i]);
                m_inf[i] = e_req[i];
                if (e_req[i]) begin
                    m_infe[i] = '{pc: m_pc[i], insn: m_pc[i] ^ key};
                    m_pc[i]   = m_pc[i] + 32'd4;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (valid_w[i] === 1'b1 && ready_i === 1'b1) begin
                if (sb[i].size() == 0) begin
                    chk("unexpected_accept", i, pc_w[i], 32'hxxxx_xxxx);
                end else begin
                    ent_t e;
                    e = sb[i].pop_front();
                    chk("accept_pc", i, pc_w[i], e.pc);
                    chk("accept_insn", i, insn_w[i], e.insn);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b0;
        imem_data[0] = '0; imem_data[1] = '0;
        key = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            mem_v[i] = 1'b0;
        end
        repeat (2) step(1, 0, 0, 0);
        // steady stream
        repeat (10) step(0, 0, 0, 1);
        // stall until full, then drain
        step(1, 0, 0, 0);
        repeat (8) step(0, 0, 0, 0);
        repeat (8) step(0, 0, 0, 1);
        // redirect with count=3, inflight=1 (DEPTH=4)
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        step(0, 1, 32'h0100_0103, 0);
        repeat (6) step(0, 0, 0, 1);
        // redirect together with a dequeue
        step(0, 1, 32'h0100_0000, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 32'h0100_0200, 1);
        repeat (6) step(0, 0, 0, 1);
        // reset mid-stream
        repeat (3) step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        repeat (5) step(0, 0, 0, 1);
        // alternating backpressure
        for (int k = 0; k < 50; k++) step(0, 0, 0, (k % 2) == 0);
        // PC wrap
        step(0, 1, 32'hFFFF_FFFC, 1);
        repeat (6) step(0, 0, 0, 1);
        // random traffic
        key = $urandom() | 32'h1;
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom(), 1'($urandom_range(0, 1)));
        // redirect counter saturation
        step(1, 0, 0, 1);
        repeat (65540) step(0, 1, $urandom(), 1);
        repeat (8) step(0, 0, 0, 1);
        for (int i = 0; i < 2; i++) chk("scoreboard_drained", i, 32'(sb[i].size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
